// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file's single write port.
// Round-robin req/gnt arbitration between NREQ requesters, one registered
// write stage ahead of the register file, and a same-cycle read bypass that
// hides the register file's read-old-value-on-write behaviour.
module regfile_wb_arbiter #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREQ = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic [NREQ-1:0]      i_Req,
    input  logic [5*NREQ-1:0]    i_Wnum,
    input  logic [XLEN*NREQ-1:0] i_Wd,
    output logic [NREQ-1:0]      o_Gnt,
    input  logic                 i_Stall,
    output logic                 o_Wen,
    output logic [4:0]           o_Wnum,
    output logic [XLEN-1:0]      o_Wd,
    input  logic [4:0]           i_Rnum1,
    input  logic [4:0]           i_Rnum2,
    input  logic [XLEN-1:0]      i_RfRd1,
    input  logic [XLEN-1:0]      i_RfRd2,
    output logic [XLEN-1:0]      o_Rd1,
    output logic [XLEN-1:0]      o_Rd2
);

    localparam int unsigned PW = $clog2(NREQ);
    localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

    generate
        if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
            $error("regfile_wb_arbiter: NREQ must be in 2..8");
        end
    endgenerate

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   gnt_idx;
    logic [PW-1:0]   cand;
    logic            gnt_valid;
    logic [4:0]      gnt_wnum;
    logic [XLEN-1:0] gnt_wd;

    // Round-robin scan from ptr; first active request wins, blocked by stall or reset.
    always_comb begin
        o_Gnt     = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = '0;
        if (i_rstn && !i_Stall) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                cand = PW'((32'(ptr) + k) % NREQ);
                if (!gnt_valid && i_Req[cand]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = cand;
                end
            end
            if (gnt_valid) begin
                o_Gnt[gnt_idx] = 1'b1;
            end
        end
        gnt_wnum = i_Wnum[5*gnt_idx +: 5];
        gnt_wd   = i_Wd[XLEN*gnt_idx +: XLEN];
    end

    // Pointer advance and registered write stage toward the register file.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ptr    <= '0;
            o_Wen  <= 1'b0;
            o_Wnum <= '0;
            o_Wd   <= '0;
        end else begin
            o_Wen <= gnt_valid && (gnt_wnum != 5'd0);
            if (gnt_valid) begin
                ptr    <= (gnt_idx == LAST) ? '0 : gnt_idx + PW'(1);
                o_Wnum <= gnt_wnum;
                o_Wd   <= gnt_wd;
            end
        end
    end

    // Same-cycle bypass of the pending write onto both read ports; x0 never bypasses.
    always_comb begin
        o_Rd1 = i_RfRd1;
        o_Rd2 = i_RfRd2;
        if (o_Wen && o_Wnum == i_Rnum1 && i_Rnum1 != 5'd0) begin
            o_Rd1 = o_Wd;
        end
        if (o_Wen && o_Wnum == i_Rnum2 && i_Rnum2 != 5'd0) begin
            o_Rd2 = o_Wd;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed stimulus, expected writes queued
// per grant and checked by an independent monitor when o_Wen is seen.
module tb_regfile_wb_arbiter;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREQ = 3;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req;
    logic [5*NREQ-1:0]    wnum;
    logic [XLEN*NREQ-1:0] wd;
    logic [NREQ-1:0]      gnt;
    logic                 stall;
    logic                 wen;
    logic [4:0]           wnum_o;
    logic [XLEN-1:0]      wd_o;
    logic [4:0]           rnum1, rnum2;
    logic [XLEN-1:0]      rfrd1, rfrd2, rd1, rd2;

    typedef struct {
        logic [4:0]      n;
        logic [XLEN-1:0] d;
    } wr_t;

    wr_t sb[$];
    int  total = 0;
    int  bad   = 0;

    regfile_wb_arbiter #(.XLEN(XLEN), .NREQ(NREQ)) dut (
        .i_clk   (clk),
        .i_rstn  (rst_n),
        .i_Req   (req),
        .i_Wnum  (wnum),
        .i_Wd    (wd),
        .o_Gnt   (gnt),
        .i_Stall (stall),
        .o_Wen   (wen),
        .o_Wnum  (wnum_o),
        .o_Wd    (wd_o),
        .i_Rnum1 (rnum1),
        .i_Rnum2 (rnum2),
        .i_RfRd1 (rfrd1),
        .i_RfRd2 (rfrd2),
        .o_Rd1   (rd1),
        .o_Rd2   (rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_slice(input int n, input logic [4:0] num, input logic [XLEN-1:0] data);
        wnum[5*n +: 5]       = num;
        wd[XLEN*n +: XLEN]   = data;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every observed write must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && wen) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got wnum=%0d wd=%h expected no write", wnum_o, wd_o);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_wnum", 64'(wnum_o), 64'(e.n));
                check("wr_wd", 64'(wd_o), 64'(e.d));
            end
        end
    end

    logic [NREQ-1:0] fair_seq [6];

    initial begin
        fair_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        rst_n = 1'b0;
        req   = 3'b111;
        stall = 1'b0;
        wnum  = '0;
        wd    = '0;
        rnum1 = '0;
        rnum2 = '0;
        rfrd1 = '0;
        rfrd2 = '0;
        set_slice(0, 5'd1, 32'hA000_0000);
        set_slice(1, 5'd2, 32'hA111_1111);
        set_slice(2, 5'd3, 32'hA222_2222);

        // Reset with all requesting
        next_cycle();
        next_cycle();
        check("rst_gnt", 64'(gnt), 64'(0));
        check("rst_wen", 64'(wen), 64'(0));
        check("rst_wnum", 64'(wnum_o), 64'(0));
        check("rst_wd", 64'(wd_o), 64'(0));

        // Release reset; fairness over six cycles
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            check("fair_gnt", 64'(gnt), 64'(fair_seq[i]));
            case (i % 3)
                0: sb.push_back('{5'd1, 32'hA000_0000});
                1: sb.push_back('{5'd2, 32'hA111_1111});
                default: sb.push_back('{5'd3, 32'hA222_2222});
            endcase
            next_cycle();
        end
        req = '0;
        next_cycle();

        // Single write from requester 1 (ptr = 0)
        set_slice(1, 5'd5, 32'hDEAD_BEEF);
        req = 3'b010;
        #1;
        check("single_gnt", 64'(gnt), 64'(3'b010));
        sb.push_back('{5'd5, 32'hDEAD_BEEF});
        next_cycle();
        req = '0;
        #1;
        check("idle_gnt", 64'(gnt), 64'(0));
        check("single_wen", 64'(wen), 64'(1));
        next_cycle();
        check("single_wen_drop", 64'(wen), 64'(0));

        // x0 write from requester 0 (ptr = 2): granted, no write enable
        set_slice(0, 5'd0, 32'hFFFF_FFFF);
        req = 3'b001;
        #1;
        check("x0_gnt", 64'(gnt), 64'(3'b001));
        next_cycle();
        req = '0;
        check("x0_wen", 64'(wen), 64'(0));

        // Stall holds off requester 2 for three cycles (ptr = 1)
        stall = 1'b1;
        req   = 3'b100;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_gnt", 64'(gnt), 64'(0));
            next_cycle();
            check("stall_wen", 64'(wen), 64'(0));
        end
        stall = 1'b0;
        #1;
        check("unstall_gnt", 64'(gnt), 64'(3'b100));
        sb.push_back('{5'd3, 32'hA222_2222});
        next_cycle();
        req = '0;
        next_cycle();

        // Bypass: put x7 <= 0x12345678 in the write stage (ptr = 0)
        set_slice(0, 5'd7, 32'h1234_5678);
        req = 3'b001;
        #1;
        check("byp_gnt", 64'(gnt), 64'(3'b001));
        sb.push_back('{5'd7, 32'h1234_5678});
        next_cycle();
        req   = '0;
        rnum1 = 5'd7;
        rfrd1 = 32'hAAAA_AAAA;
        rnum2 = 5'd8;
        rfrd2 = 32'h0000_0055;
        #1;
        check("byp_rd1_hit", 64'(rd1), 64'(32'h1234_5678));
        check("byp_rd2_miss", 64'(rd2), 64'(32'h0000_0055));
        rnum2 = 5'd7;
        #1;
        check("byp_rd2_hit", 64'(rd2), 64'(32'h1234_5678));
        rnum1 = 5'd0;
        rnum2 = 5'd0;
        rfrd1 = 32'h0000_0011;
        rfrd2 = 32'h0000_0022;
        #1;
        check("byp_rd1_x0", 64'(rd1), 64'(32'h0000_0011));
        check("byp_rd2_x0", 64'(rd2), 64'(32'h0000_0022));
        next_cycle();
        rnum1 = 5'd7;
        rfrd1 = 32'h0BAD_0BAD;
        #1;
        check("byp_no_wen", 64'(rd1), 64'(32'h0BAD_0BAD));

        // Async reset with a write in flight: no write must be observed (ptr = 1)
        next_cycle();
        set_slice(1, 5'd9, 32'hCAFE_F00D);
        req = 3'b010;
        #1;
        check("ar_gnt", 64'(gnt), 64'(3'b010));
        next_cycle();
        req = '0;
        check("ar_wen_pre", 64'(wen), 64'(1));
        rst_n = 1'b0;
        #1;
        check("ar_wen_now", 64'(wen), 64'(0));
        check("ar_wnum_now", 64'(wnum_o), 64'(0));
        rst_n = 1'b1;
        set_slice(0, 5'd4, 32'h0404_0404);
        req = 3'b111;
        #1;
        check("ar_prio0", 64'(gnt), 64'(3'b001));
        sb.push_back('{5'd4, 32'h0404_0404});
        next_cycle();
        req = '0;
        next_cycle();
        next_cycle();

        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
